// File: rtl/mprj_wb_guard_pkg.sv
// ----------------------------------------------------------------------------
// mprj_wb_guard_pkg
// Shared types and constants for the management-core to user-project
// Wishbone guard bridge:
//   state_e          : bridge FSM encoding (IDLE / REQ / DONE), 2 bits
//   DEFAULT_ERR_DATA : read data returned to the core when a request times out
//   STATS_W          : width of the timeout statistics counter
//   sat_inc()        : saturating increment used by the statistics counter
// ----------------------------------------------------------------------------
package mprj_wb_guard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;
    localparam int          STATS_W          = 16;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        logic [STATS_W-1:0] r;
        if (v == {STATS_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(STATS_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/mprj_wb_guard_if.sv
// ----------------------------------------------------------------------------
// mprj_wb_guard_if
// Classic Wishbone request/response bundle. One instance carries the core
// side (the guard is the slave there), another the user side (the guard is
// the master there).
//   cyc/stb/we/sel/adr/dat_w : request, driven by the master
//   ack/dat_r                : response, driven by the slave
// ----------------------------------------------------------------------------
interface mprj_wb_guard_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic        ack;
    logic [31:0] dat_r;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  ack, dat_r
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output ack, dat_r
    );

endinterface

// File: rtl/mprj_wb_timer.sv
// ----------------------------------------------------------------------------
// mprj_wb_timer
// Clear/enable cycle counter that flags the last allowed cycle of a request.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : force the count to zero (has priority over en_i)
//   en_i         : advance the count by one
//   expired_o    : count equals TIMEOUT_CYCLES-1 (last cycle before a forced ack)
// TIMEOUT_CYCLES must lie in 1 .. 2**CNT_W-1.
// ----------------------------------------------------------------------------
module mprj_wb_timer #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + ONE_CNT;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/mprj_wb_guard.sv
// ----------------------------------------------------------------------------
// mprj_wb_guard
// Registered Wishbone bridge from the management core's user-project bus to
// the user project area. Every request is re-timed, the response is returned
// one cycle later, user acks are ignored while mprj_wb_iena is low, and a
// request the user never acks is terminated with ERR_DATA so the CPU cannot
// hang on a dead or unpowered user design.
//
// Ports:
//   core_clk, core_rst : clock, asynchronous active-high reset
//   mprj_wb_iena       : user return-path enable (s ack ignored when 0)
//   m_if (slave)       : core side bus  (cyc/stb/we/sel/adr/dat_w in, ack/dat_r out)
//   s_if (master)      : user side bus  (cyc/stb/we/sel/adr/dat_w out, ack/dat_r in)
//   timeout_clr        : clears timeout_flag (and timeout_count)
//   timeout_flag       : sticky, a timeout has occurred
//   err_adr_o          : address of the most recent timed-out request
//   timeout_count      : saturating timeout counter
//
// Build option: define MPRJ_WB_GUARD_STATS_EN to implement timeout_count;
// otherwise it is tied to zero and no counter flops exist.
// ----------------------------------------------------------------------------
module mprj_wb_guard
    import mprj_wb_guard_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          CNT_W          = 8,
    parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic                core_clk,
    input  logic                core_rst,
    input  logic                mprj_wb_iena,
    mprj_wb_guard_if.slave      m_if,
    mprj_wb_guard_if.master     s_if,
    input  logic                timeout_clr,
    output logic                timeout_flag,
    output logic [31:0]         err_adr_o,
    output logic [STATS_W-1:0]  timeout_count
);

    state_e      state_q,   state_d;
    logic        m_ack_q,   m_ack_d;
    logic [31:0] m_dat_q,   m_dat_d;
    logic        s_cyc_q,   s_cyc_d;
    logic        s_stb_q,   s_stb_d;
    logic        s_we_q,    s_we_d;
    logic [3:0]  s_sel_q,   s_sel_d;
    logic [31:0] s_adr_q,   s_adr_d;
    logic [31:0] s_dat_q,   s_dat_d;
    logic [31:0] err_adr_q, err_adr_d;
    logic        flag_q,    flag_d;

    logic        user_ack_s;
    logic        expired_s;
    logic        tmr_clr_s;
    logic        tmr_en_s;
    logic        timeout_evt_s;

    // A user ack only counts while the return path is enabled.
    assign user_ack_s = s_if.ack & mprj_wb_iena;

    mprj_wb_timer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (core_clk),
        .rst_i     (core_rst),
        .clr_i     (tmr_clr_s),
        .en_i      (tmr_en_s),
        .expired_o (expired_s)
    );

    // Next state and next register values for the bridge FSM.
    always_comb begin
        state_d       = state_q;
        m_ack_d       = 1'b0;
        m_dat_d       = m_dat_q;
        s_cyc_d       = s_cyc_q;
        s_stb_d       = s_stb_q;
        s_we_d        = s_we_q;
        s_sel_d       = s_sel_q;
        s_adr_d       = s_adr_q;
        s_dat_d       = s_dat_q;
        err_adr_d     = err_adr_q;
        tmr_clr_s     = 1'b1;       // counter sits at zero outside REQ
        tmr_en_s      = 1'b0;
        timeout_evt_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m_if.cyc & m_if.stb) begin
                    s_we_d  = m_if.we;
                    s_sel_d = m_if.sel;
                    s_adr_d = m_if.adr;
                    s_dat_d = m_if.dat_w;
                    s_cyc_d = 1'b1;
                    s_stb_d = 1'b1;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_REQ: begin
                tmr_clr_s = 1'b0;
                if (!m_if.cyc) begin
                    // Core abandoned the cycle: withdraw quietly.
                    s_cyc_d = 1'b0;
                    s_stb_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (user_ack_s) begin
                    // Forwarded on writes too; the core ignores it there.
                    m_dat_d = s_if.dat_r;
                    s_cyc_d = 1'b0;
                    s_stb_d = 1'b0;
                    m_ack_d = 1'b1;
                    state_d = ST_DONE;
                end else if (expired_s) begin
                    m_dat_d       = ERR_DATA;
                    err_adr_d     = s_adr_q;
                    timeout_evt_s = 1'b1;
                    s_cyc_d       = 1'b0;
                    s_stb_d       = 1'b0;
                    m_ack_d       = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    tmr_en_s = 1'b1;
                end
            end

            ST_DONE: begin
                // m_stb_i is deliberately not looked at here: the core still
                // holds it during the ack cycle.
                state_d = ST_IDLE;
            end

            default: begin
                s_cyc_d = 1'b0;
                s_stb_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // A new timeout outranks a simultaneous clear.
        if (timeout_evt_s) begin
            flag_d = 1'b1;
        end else if (timeout_clr) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q;
        end
    end

    // Bridge state and output registers.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state_q   <= ST_IDLE;
            m_ack_q   <= 1'b0;
            m_dat_q   <= 32'h0000_0000;
            s_cyc_q   <= 1'b0;
            s_stb_q   <= 1'b0;
            s_we_q    <= 1'b0;
            s_sel_q   <= 4'h0;
            s_adr_q   <= 32'h0000_0000;
            s_dat_q   <= 32'h0000_0000;
            err_adr_q <= 32'h0000_0000;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_ack_q   <= m_ack_d;
            m_dat_q   <= m_dat_d;
            s_cyc_q   <= s_cyc_d;
            s_stb_q   <= s_stb_d;
            s_we_q    <= s_we_d;
            s_sel_q   <= s_sel_d;
            s_adr_q   <= s_adr_d;
            s_dat_q   <= s_dat_d;
            err_adr_q <= err_adr_d;
            flag_q    <= flag_d;
        end
    end

`ifdef MPRJ_WB_GUARD_STATS_EN
    logic [STATS_W-1:0] stats_q;
    logic [STATS_W-1:0] stats_d;

    // Clear restarts the count; a timeout in the same cycle counts as the first.
    always_comb begin
        stats_d = stats_q;
        if (timeout_clr) begin
            if (timeout_evt_s) begin
                stats_d = {{(STATS_W-1){1'b0}}, 1'b1};
            end else begin
                stats_d = {STATS_W{1'b0}};
            end
        end else if (timeout_evt_s) begin
            stats_d = sat_inc(stats_q);
        end else begin
            stats_d = stats_q;
        end
    end

    // Timeout statistics register.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            stats_q <= {STATS_W{1'b0}};
        end else begin
            stats_q <= stats_d;
        end
    end

    assign timeout_count = stats_q;
`else
    assign timeout_count = {STATS_W{1'b0}};
`endif

    assign m_if.ack   = m_ack_q;
    assign m_if.dat_r = m_dat_q;
    assign s_if.cyc   = s_cyc_q;
    assign s_if.stb   = s_stb_q;
    assign s_if.we    = s_we_q;
    assign s_if.sel   = s_sel_q;
    assign s_if.adr   = s_adr_q;
    assign s_if.dat_w = s_dat_q;
    assign timeout_flag = flag_q;
    assign err_adr_o    = err_adr_q;

endmodule

// File: tb/tb_mprj_wb_guard.sv
// ----------------------------------------------------------------------------
// tb_mprj_wb_guard
// Directed self-checking bench for mprj_wb_guard with TIMEOUT_CYCLES = 8.
// Inputs change 1 ns after a rising edge; outputs are read at the same point.
// ----------------------------------------------------------------------------
module tb_mprj_wb_guard;

    logic        core_clk;
    logic        core_rst;
    logic        mprj_wb_iena;
    logic        timeout_clr;
    logic        timeout_flag;
    logic [31:0] err_adr_o;
    logic [15:0] timeout_count;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    mprj_wb_guard_if m_bus ();
    mprj_wb_guard_if s_bus ();

    mprj_wb_guard #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (8),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .core_clk      (core_clk),
        .core_rst      (core_rst),
        .mprj_wb_iena  (mprj_wb_iena),
        .m_if          (m_bus.slave),
        .s_if          (s_bus.master),
        .timeout_clr   (timeout_clr),
        .timeout_flag  (timeout_flag),
        .err_adr_o     (err_adr_o),
        .timeout_count (timeout_count)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic set_req(input logic we, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] dat);
        m_bus.cyc   = 1'b1;
        m_bus.stb   = 1'b1;
        m_bus.we    = we;
        m_bus.sel   = sel;
        m_bus.adr   = adr;
        m_bus.dat_w = dat;
    endtask

    task automatic end_req();
        m_bus.cyc = 1'b0;
        m_bus.stb = 1'b0;
    endtask

    // Full unanswered request; optionally pulses timeout_clr in the expiry cycle.
    task automatic run_timeout(input logic [31:0] adr, input logic clr_at_expiry);
        set_req(1'b0, 4'hF, adr, 32'h0);
        tick();                 // captured, REQ cycle 1
        repeat (7) tick();      // REQ cycles 2..8
        timeout_clr = clr_at_expiry;
        tick();                 // expiry edge
        timeout_clr = 1'b0;
        end_req();
        tick();                 // DONE -> IDLE
    endtask

    task automatic test_reset();
        core_rst = 1'b1;
        tick();
        tick();
        chk_cnt++; if (m_bus.ack !== 1'b0) $display("FAIL rst_ack got=%0h exp=0", m_bus.ack); else pass_cnt++;
        chk_cnt++; if (m_bus.dat_r !== 32'h0) $display("FAIL rst_mdat got=%h exp=0", m_bus.dat_r); else pass_cnt++;
        chk_cnt++; if ({s_bus.cyc, s_bus.stb} !== 2'b00) $display("FAIL rst_scyc_stb got=%b exp=00", {s_bus.cyc, s_bus.stb}); else pass_cnt++;
        chk_cnt++; if (s_bus.adr !== 32'h0) $display("FAIL rst_sadr got=%h exp=0", s_bus.adr); else pass_cnt++;
        chk_cnt++; if (timeout_flag !== 1'b0) $display("FAIL rst_flag got=%0h exp=0", timeout_flag); else pass_cnt++;
        chk_cnt++; if (err_adr_o !== 32'h0) $display("FAIL rst_erradr got=%h exp=0", err_adr_o); else pass_cnt++;
        chk_cnt++; if (timeout_count !== 16'h0) $display("FAIL rst_tcount got=%h exp=0", timeout_count); else pass_cnt++;
        core_rst = 1'b0;
        tick();
    endtask

    task automatic test_read();
        set_req(1'b0, 4'hF, 32'h3000_0004, 32'h0);
        tick();     // stb-sampling edge
        chk_cnt++; if ({s_bus.cyc, s_bus.stb, s_bus.we} !== 3'b110) $display("FAIL rd_sreq got=%b exp=110", {s_bus.cyc, s_bus.stb, s_bus.we}); else pass_cnt++;
        chk_cnt++; if (s_bus.adr !== 32'h3000_0004) $display("FAIL rd_sadr got=%h exp=30000004", s_bus.adr); else pass_cnt++;
        chk_cnt++; if (m_bus.ack !== 1'b0) $display("FAIL rd_ack_early got=%0h exp=0", m_bus.ack); else pass_cnt++;
        s_bus.ack   = 1'b1;
        s_bus.dat_r = 32'h1234_5678;
        tick();     // 2nd edge after sampling
        s_bus.ack = 1'b0;
        chk_cnt++; if (m_bus.ack !== 1'b1) $display("FAIL rd_ack got=%0h exp=1", m_bus.ack); else pass_cnt++;
        chk_cnt++; if (m_bus.dat_r !== 32'h1234_5678) $display("FAIL rd_data got=%h exp=12345678", m_bus.dat_r); else pass_cnt++;
        chk_cnt++; if (s_bus.stb !== 1'b0) $display("FAIL rd_sstb_drop got=%0h exp=0", s_bus.stb); else pass_cnt++;
        end_req();
        tick();
        chk_cnt++; if (m_bus.ack !== 1'b0) $display("FAIL rd_ack_pulse got=%0h exp=0", m_bus.ack); else pass_cnt++;
        chk_cnt++; if (m_bus.dat_r !== 32'h1234_5678) $display("FAIL rd_data_hold got=%h exp=12345678", m_bus.dat_r); else pass_cnt++;
    endtask

    task automatic test_write();
        set_req(1'b1, 4'b0011, 32'h3000_0010, 32'hA5A5_A5A5);
        tick();
        chk_cnt++; if (s_bus.dat_w !== 32'hA5A5_A5A5) $display("FAIL wr_sdat got=%h exp=a5a5a5a5", s_bus.dat_w); else pass_cnt++;
        chk_cnt++; if (s_bus.sel !== 4'b0011) $display("FAIL wr_ssel got=%b exp=0011", s_bus.sel); else pass_cnt++;
        chk_cnt++; if (s_bus.adr !== 32'h3000_0010) $display("FAIL wr_sadr got=%h exp=30000010", s_bus.adr); else pass_cnt++;
        chk_cnt++; if ({s_bus.stb, s_bus.we} !== 2'b11) $display("FAIL wr_sstb_we got=%b exp=11", {s_bus.stb, s_bus.we}); else pass_cnt++;
        s_bus.ack   = 1'b1;
        s_bus.dat_r = 32'h0000_0055;
        tick();
        s_bus.ack = 1'b0;
        chk_cnt++; if (m_bus.ack !== 1'b1) $display("FAIL wr_ack got=%0h exp=1", m_bus.ack); else pass_cnt++;
        chk_cnt++; if (m_bus.dat_r !== 32'h0000_0055) $display("FAIL wr_mdat got=%h exp=00000055", m_bus.dat_r); else pass_cnt++;
        tick();     // core still holds stb through DONE
        chk_cnt++; if ({m_bus.ack, s_bus.stb} !== 2'b00) $display("FAIL wr_no_restrobe got=%b exp=00", {m_bus.ack, s_bus.stb}); else pass_cnt++;
        end_req();
        tick();
        chk_cnt++; if ({m_bus.ack, s_bus.stb} !== 2'b00) $display("FAIL wr_idle got=%b exp=00", {m_bus.ack, s_bus.stb}); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        set_req(1'b0, 4'hF, 32'h3000_0100, 32'h0);
        tick();
        repeat (7) begin
            tick();
            if (m_bus.ack) early++;
        end
        chk_cnt++; if (early !== 0) $display("FAIL to_early_ack got=%0d exp=0", early); else pass_cnt++;
        tick();
        chk_cnt++; if (m_bus.ack !== 1'b1) $display("FAIL to_ack got=%0h exp=1", m_bus.ack); else pass_cnt++;
        chk_cnt++; if (m_bus.dat_r !== 32'hDEAD_BEEF) $display("FAIL to_data got=%h exp=deadbeef", m_bus.dat_r); else pass_cnt++;
        chk_cnt++; if (timeout_flag !== 1'b1) $display("FAIL to_flag got=%0h exp=1", timeout_flag); else pass_cnt++;
        chk_cnt++; if (err_adr_o !== 32'h3000_0100) $display("FAIL to_erradr got=%h exp=30000100", err_adr_o); else pass_cnt++;
        chk_cnt++; if (s_bus.cyc !== 1'b0) $display("FAIL to_scyc got=%0h exp=0", s_bus.cyc); else pass_cnt++;
        end_req();
        tick();
        chk_cnt++; if (m_bus.ack !== 1'b0) $display("FAIL to_ack_pulse got=%0h exp=0", m_bus.ack); else pass_cnt++;
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
        chk_cnt++; if (timeout_flag !== 1'b0) $display("FAIL to_flag_clr got=%0h exp=0", timeout_flag); else pass_cnt++;
        chk_cnt++; if (err_adr_o !== 32'h3000_0100) $display("FAIL to_erradr_hold got=%h exp=30000100", err_adr_o); else pass_cnt++;
    endtask

    task automatic test_iena_off();
        int n;
        n = 0;
        mprj_wb_iena = 1'b0;
        s_bus.ack    = 1'b1;
        s_bus.dat_r  = 32'h1111_2222;
        set_req(1'b0, 4'hF, 32'h3000_0200, 32'h0);
        tick();
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (m_bus.ack === 1'b1) begin
                n = i;
                break;
            end
        end
        chk_cnt++; if (n !== 8) $display("FAIL iena_ack_cycle got=%0d exp=8", n); else pass_cnt++;
        chk_cnt++; if (m_bus.dat_r !== 32'hDEAD_BEEF) $display("FAIL iena_data got=%h exp=deadbeef", m_bus.dat_r); else pass_cnt++;
        chk_cnt++; if (timeout_flag !== 1'b1) $display("FAIL iena_flag got=%0h exp=1", timeout_flag); else pass_cnt++;
        end_req();
        s_bus.ack    = 1'b0;
        mprj_wb_iena = 1'b1;
        tick();
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
    endtask

    task automatic test_ack_at_expiry();
        set_req(1'b0, 4'hF, 32'h3000_0300, 32'h0);
        tick();
        repeat (7) tick();      // now in REQ cycle 8, the expiry cycle
        chk_cnt++; if (m_bus.ack !== 1'b0) $display("FAIL race_ack_early got=%0h exp=0", m_bus.ack); else pass_cnt++;
        s_bus.ack   = 1'b1;
        s_bus.dat_r = 32'hCAFE_F00D;
        tick();
        s_bus.ack = 1'b0;
        chk_cnt++; if (m_bus.ack !== 1'b1) $display("FAIL race_ack got=%0h exp=1", m_bus.ack); else pass_cnt++;
        chk_cnt++; if (m_bus.dat_r !== 32'hCAFE_F00D) $display("FAIL race_data got=%h exp=cafef00d", m_bus.dat_r); else pass_cnt++;
        chk_cnt++; if (timeout_flag !== 1'b0) $display("FAIL race_flag got=%0h exp=0", timeout_flag); else pass_cnt++;
        end_req();
        tick();
    endtask

    task automatic test_abort();
        int acks;
        acks = 0;
        set_req(1'b0, 4'hF, 32'h3000_0400, 32'h0);
        tick();     // REQ cycle 1
        tick();     // REQ cycle 2
        tick();     // REQ cycle 3
        end_req();
        tick();
        if (m_bus.ack) acks++;
        chk_cnt++; if ({s_bus.cyc, s_bus.stb} !== 2'b00) $display("FAIL abort_sdrop got=%b exp=00", {s_bus.cyc, s_bus.stb}); else pass_cnt++;
        repeat (10) begin
            tick();
            if (m_bus.ack) acks++;
        end
        chk_cnt++; if (acks !== 0) $display("FAIL abort_no_ack got=%0d exp=0", acks); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [9:0] mask;
        int k;
        mask = 10'b0;
        k    = 0;
        s_bus.ack   = 1'b1;
        s_bus.dat_r = 32'hB0B0_0000;
        set_req(1'b0, 4'hF, 32'h3000_1000, 32'h0);
        for (int e = 0; e < 10; e++) begin
            tick();
            if (m_bus.ack === 1'b1) begin
                mask[e]     = 1'b1;
                k++;
                m_bus.adr   = 32'h3000_1000 + 32'(4 * k);
                s_bus.dat_r = 32'hB0B0_0000 + 32'(k);
            end
        end
        chk_cnt++; if (mask !== 10'b00_1001_0010) $display("FAIL b2b_ack_edges got=%b exp=0010010010", mask); else pass_cnt++;
        chk_cnt++; if (m_bus.dat_r !== 32'hB0B0_0002) $display("FAIL b2b_data got=%h exp=b0b00002", m_bus.dat_r); else pass_cnt++;
        chk_cnt++; if (s_bus.adr !== 32'h3000_100C) $display("FAIL b2b_sadr got=%h exp=3000100c", s_bus.adr); else pass_cnt++;
        s_bus.ack = 1'b0;
        end_req();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_req();
        set_req(1'b0, 4'hF, 32'h3000_0500, 32'h0);
        tick();
        chk_cnt++; if (s_bus.cyc !== 1'b1) $display("FAIL mrst_pre got=%0h exp=1", s_bus.cyc); else pass_cnt++;
        core_rst = 1'b1;
        #1;
        chk_cnt++; if ({s_bus.cyc, s_bus.stb, m_bus.ack} !== 3'b000) $display("FAIL mrst_drop got=%b exp=000", {s_bus.cyc, s_bus.stb, m_bus.ack}); else pass_cnt++;
        end_req();
        tick();
        core_rst = 1'b0;
        tick();
    endtask

    task automatic test_stats();
        logic [15:0] exp3;
        logic [15:0] exp1;
`ifdef MPRJ_WB_GUARD_STATS_EN
        exp3 = 16'd3;
        exp1 = 16'd1;
`else
        exp3 = 16'd0;
        exp1 = 16'd0;
`endif
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
        run_timeout(32'h3000_0600, 1'b0);
        run_timeout(32'h3000_0604, 1'b0);
        run_timeout(32'h3000_0608, 1'b0);
        chk_cnt++; if (timeout_count !== exp3) $display("FAIL stats_three got=%0d exp=%0d", timeout_count, exp3); else pass_cnt++;
        run_timeout(32'h3000_060C, 1'b1);
        chk_cnt++; if (timeout_count !== exp1) $display("FAIL stats_clr_inc got=%0d exp=%0d", timeout_count, exp1); else pass_cnt++;
        chk_cnt++; if (timeout_flag !== 1'b1) $display("FAIL flag_set_wins got=%0h exp=1", timeout_flag); else pass_cnt++;
        chk_cnt++; if (err_adr_o !== 32'h3000_060C) $display("FAIL stats_erradr got=%h exp=3000060c", err_adr_o); else pass_cnt++;
    endtask

    initial begin
        core_rst     = 1'b1;
        mprj_wb_iena = 1'b1;
        timeout_clr  = 1'b0;
        m_bus.cyc    = 1'b0;
        m_bus.stb    = 1'b0;
        m_bus.we     = 1'b0;
        m_bus.sel    = 4'h0;
        m_bus.adr    = 32'h0;
        m_bus.dat_w  = 32'h0;
        s_bus.ack    = 1'b0;
        s_bus.dat_r  = 32'h0;

        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_iena_off();
        test_ack_at_expiry();
        test_abort();
        test_back_to_back();
        test_reset_mid_req();
        test_stats();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired passed=%0d total=%0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

endmodule
